// File: rtl/burst_read_master.sv
// Avalon-MM burst read master: fetches a block of words in bursts into a show-ahead FIFO,
// issuing a burst only when the FIFO is guaranteed room for every word it will return.
module burst_read_master #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BURST_COUNT     = 8,
  parameter int unsigned BURST_WIDTH     = 4,
  parameter int unsigned LENGTH_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]   ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]    ctrl_length,
  output logic                       ctrl_busy,
  output logic                       ctrl_done,
  output logic [ADDRESS_WIDTH-1:0]   master_address,
  output logic                       master_read,
  output logic [BURST_WIDTH-1:0]     master_burstcount,
  input  logic                       master_waitrequest,
  input  logic                       master_readdatavalid,
  input  logic [DATA_WIDTH-1:0]      master_readdata,
  input  logic                       user_read,
  output logic                       user_valid,
  output logic [DATA_WIDTH-1:0]      user_data,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned BPW        = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BPW);
  localparam int unsigned CW         = LENGTH_WIDTH + 2;
  localparam int unsigned LVW        = FIFO_DEPTH_LOG2 + 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~(ADDRESS_WIDTH'(BPW) - ADDRESS_WIDTH'(1));

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LENGTH_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [LENGTH_WIDTH-1:0]  to_receive_q, to_receive_d;
  logic                     done_q, done_d;

  logic [LENGTH_WIDTH-1:0]  bs;
  logic                     space_ok;
  logic                     accept;
  logic                     wr;
  logic                     pop;
  logic                     last_beat;

  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   level_q;

  always_comb begin
    bs = (remaining_q < LENGTH_WIDTH'(BURST_COUNT)) ? remaining_q : LENGTH_WIDTH'(BURST_COUNT);
    // Reserve room for data already requested but not yet returned.
    space_ok = (CW'(level_q) + CW'(outstanding_q) + CW'(bs)) <= CW'(FIFO_DEPTH);
  end

  assign master_read       = (state_q == ISSUE) && space_ok;
  assign master_address    = addr_q;
  assign master_burstcount = bs[BURST_WIDTH-1:0];
  assign ctrl_busy         = (state_q != IDLE);
  assign ctrl_done         = done_q;

  assign accept    = master_read && !master_waitrequest;
  // Beats arriving while idle are leftovers from an aborted transfer.
  assign wr        = master_readdatavalid && (state_q != IDLE);
  assign last_beat = wr && (to_receive_q == LENGTH_WIDTH'(1));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    to_receive_d  = to_receive_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          if (ctrl_length != '0) begin
            addr_d        = ctrl_baseaddress & ADDR_MASK;
            remaining_d   = ctrl_length;
            to_receive_d  = ctrl_length;
            outstanding_d = '0;
            state_d       = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_d      = addr_q + (ADDRESS_WIDTH'(bs) << BYTE_SHIFT);
          remaining_d = remaining_q - bs;
          if (remaining_q == bs) state_d = DRAIN;
        end
      end
      default: ;
    endcase

    if (state_q != IDLE) begin
      outstanding_d = outstanding_q + (accept ? bs : '0) - LENGTH_WIDTH'(wr);
      if (wr) to_receive_d = to_receive_q - LENGTH_WIDTH'(1);
      if (last_beat) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      to_receive_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      to_receive_q  <= to_receive_d;
      done_q        <= done_d;
    end
  end

  assign pop = user_read && (level_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      level_q <= level_q + LVW'(wr) - LVW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= master_readdata;
  end

  assign user_valid = (level_q != '0);
  assign user_data  = user_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = level_q;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wr && !pop && (level_q == LVW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_burst_read_master.sv
// Bench for burst_read_master: Avalon slave model with programmable wait, a scoreboard of
// expected FIFO words, and one task per scenario.
module tb_burst_read_master;

  localparam int AW = 32, DW = 32, BC = 8, BW = 4, LW = 16, FD = 16, FDL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_baseaddress = '0;
  logic [LW-1:0] ctrl_length = '0;
  logic          ctrl_busy, ctrl_done;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic [BW-1:0] master_burstcount;
  logic          master_waitrequest = 1'b0;
  logic          master_readdatavalid = 1'b0;
  logic [DW-1:0] master_readdata = '0;
  logic          user_read = 1'b0;
  logic          user_valid;
  logic [DW-1:0] user_data;
  logic [FDL:0]  fifo_level;

  burst_read_master #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT(BC), .BURST_WIDTH(BW),
    .LENGTH_WIDTH(LW), .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(FDL)
  ) dut (
    .clk(clk), .reset(reset),
    .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress), .ctrl_length(ctrl_length),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .master_address(master_address), .master_read(master_read),
    .master_burstcount(master_burstcount), .master_waitrequest(master_waitrequest),
    .master_readdatavalid(master_readdatavalid), .master_readdata(master_readdata),
    .user_read(user_read), .user_valid(user_valid), .user_data(user_data),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: returns word-address data one beat per cycle after acceptance.
  logic [31:0] beat_q[$];
  logic [31:0] baddr_q[$];
  int          bcnt_q[$];
  int          wait_left = 0, wait_seen = 0, hold_bad = 0, beat_cyc = 0;
  bit          holding = 0;
  logic [31:0] hold_addr = '0;
  logic [BW-1:0] hold_bc = '0;

  always @(negedge clk) begin
    if (beat_q.size() > 0) begin
      master_readdatavalid = 1'b1;
      master_readdata      = beat_q.pop_front();
      beat_cyc             = cyc;
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata      = '0;
    end
    master_waitrequest = 1'b0;
    if (!master_read) holding = 0;
    else begin
      if (holding && (master_address !== hold_addr || master_burstcount !== hold_bc)) hold_bad++;
      if (wait_left > 0) begin
        master_waitrequest = 1'b1;
        wait_left--;
        wait_seen++;
        holding   = 1;
        hold_addr = master_address;
        hold_bc   = master_burstcount;
      end else begin
        holding = 0;
        baddr_q.push_back(master_address);
        bcnt_q.push_back(int'(master_burstcount));
        for (int k = 0; k < int'(master_burstcount); k++)
          beat_q.push_back((master_address >> 2) + 32'(k));
      end
    end
  end

  // Scoreboard and event monitor.
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  int          done_cyc = 0, done_cnt = 0, read_cyc = 0;
  logic        done_busy = 1'b0;

  always @(negedge clk) begin
    if (master_read) read_cyc++;
    if (ctrl_done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = ctrl_busy;
    end
    if (user_valid && user_read) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got %0h, expected no data", user_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (user_data !== exp_word) begin
          bad++;
          $display("FAIL sb_data: got %0h want %0h", user_data, exp_word);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int len);
    ctrl_baseaddress = base;
    ctrl_length      = LW'(len);
    ctrl_start       = 1'b1;
    tick(1);
    start_cyc  = cyc;
    ctrl_start = 1'b0;
    for (int i = 0; i < len; i++) exp_q.push_back(((base & 32'hFFFF_FFFC) >> 2) + 32'(i));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt != n0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    baddr_q.delete();
    bcnt_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if ({ctrl_busy, ctrl_done, master_read, user_valid} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {ctrl_busy, ctrl_done, master_read, user_valid});
    end
    total++;
    if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++;
    if (master_address !== '0 || master_burstcount !== '0) begin
      bad++;
      $display("FAIL reset_bus: got %0h/%0d want 0/0", master_address, master_burstcount);
    end
    total++;
    if (user_data !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", user_data); end
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_len16();
    bit ok;
    int n0;
    clear_log();
    n0 = done_cnt;
    user_read = 1'b1;
    start_xfer(32'h1000, 16);
    total++;
    if (ctrl_busy !== 1'b1) begin bad++; $display("FAIL l16_busy: got %b want 1", ctrl_busy); end
    wait_done(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL l16_done: got timeout want done"); end
    total++;
    if (done_cyc != beat_cyc + 1) begin
      bad++;
      $display("FAIL l16_done_time: got cycle %0d want %0d", done_cyc, beat_cyc + 1);
    end
    total++;
    if (done_busy !== 1'b0) begin bad++; $display("FAIL l16_busy_end: got %b want 0", done_busy); end
    tick(20);
    total++;
    if (baddr_q.size() != 2 || baddr_q[0] != 32'h1000 || baddr_q[1] != 32'h1020 ||
        bcnt_q[0] != 8 || bcnt_q[1] != 8) begin
      bad++;
      $display("FAIL l16_bursts: got %0d bursts want 2 of 8 at 1000/1020", baddr_q.size());
    end
    total++;
    if (exp_q.size() != 0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL l16_drain: got %0d left/level %0d want 0/0", exp_q.size(), fifo_level);
    end
    total++;
    if (done_cnt != n0 + 1) begin bad++; $display("FAIL l16_pulses: got %0d want 1", done_cnt - n0); end
  endtask

  task automatic test_len13();
    bit ok;
    clear_log();
    user_read = 1'b1;
    start_xfer(32'h1000, 13);
    wait_done(200, ok);
    total++;
    if (!ok || done_busy !== 1'b0) begin
      bad++;
      $display("FAIL l13_done: got ok=%0d busy=%b want 1/0", ok, done_busy);
    end
    total++;
    if (done_cyc != beat_cyc + 1) begin
      bad++;
      $display("FAIL l13_done_time: got cycle %0d want %0d", done_cyc, beat_cyc + 1);
    end
    tick(20);
    total++;
    if (baddr_q.size() != 2 || baddr_q[0] != 32'h1000 || baddr_q[1] != 32'h1020 ||
        bcnt_q[0] != 8 || bcnt_q[1] != 5) begin
      bad++;
      $display("FAIL l13_bursts: got %0d bursts want 8@1000 5@1020", baddr_q.size());
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL l13_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wait();
    bit ok;
    clear_log();
    wait_seen = 0;
    hold_bad  = 0;
    wait_left = 3;
    user_read = 1'b1;
    start_xfer(32'h2000, 8);
    wait_done(200, ok);
    tick(15);
    total++;
    if (!ok) begin bad++; $display("FAIL wait_done: got timeout want done"); end
    total++;
    if (wait_seen != 3) begin bad++; $display("FAIL wait_cycles: got %0d want 3", wait_seen); end
    total++;
    if (hold_bad != 0) begin bad++; $display("FAIL wait_hold: got %0d changes want 0", hold_bad); end
    total++;
    if (baddr_q.size() != 1 || baddr_q[0] != 32'h2000 || bcnt_q[0] != 8) begin
      bad++;
      $display("FAIL wait_accepts: got %0d accepts want 1 at 2000", baddr_q.size());
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL wait_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0;
    clear_log();
    user_read = 1'b0;
    start_xfer(32'h3000, 32);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (fifo_level == 16) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL bp_fill: got level %0d want 16", fifo_level); end
    r0 = read_cyc;
    tick(10);
    total++;
    if (read_cyc != r0) begin bad++; $display("FAIL bp_read_idle: got %0d reads want 0", read_cyc - r0); end
    total++;
    if (baddr_q.size() != 2 || fifo_level !== 5'd16) begin
      bad++;
      $display("FAIL bp_hold: got %0d bursts level %0d want 2/16", baddr_q.size(), fifo_level);
    end
    user_read = 1'b1;
    tick(8);
    user_read = 1'b0;
    tick(5);
    total++;
    if (baddr_q.size() != 3 || baddr_q[2] != 32'h3040) begin
      bad++;
      $display("FAIL bp_third: got %0d bursts want 3 (third at 3040)", baddr_q.size());
    end
    user_read = 1'b1;
    wait_done(300, ok);
    tick(20);
    total++;
    if (!ok || baddr_q.size() != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_finish: got ok=%0d bursts=%0d left=%0d want 1/4/0", ok, baddr_q.size(),
               exp_q.size());
    end
  endtask

  task automatic test_len0();
    bit ok;
    int r0, n0;
    r0 = read_cyc;
    n0 = done_cnt;
    user_read = 1'b1;
    start_xfer(32'h1003, 0);
    total++;
    if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL l0_busy: got %b want 0", ctrl_busy); end
    tick(3);
    total++;
    if (done_cnt != n0 + 1 || done_cyc != start_cyc) begin
      bad++;
      $display("FAIL l0_done: got %0d pulses at %0d want 1 at %0d", done_cnt - n0, done_cyc, start_cyc);
    end
    total++;
    if (read_cyc != r0) begin bad++; $display("FAIL l0_read: got %0d reads want 0", read_cyc - r0); end
    clear_log();
    start_xfer(32'h1003, 4);
    wait_done(200, ok);
    tick(10);
    total++;
    if (!ok || baddr_q.size() != 1 || baddr_q[0] != 32'h1000 || bcnt_q[0] != 4) begin
      bad++;
      $display("FAIL align_addr: got ok=%0d bursts=%0d want one burst of 4 at 1000", ok, baddr_q.size());
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL align_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    clear_log();
    user_read = 1'b0;
    start_xfer(32'h4000, 8);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (fifo_level == 3) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_fill: got level %0d want 3", fifo_level); end
    reset = 1'b1;
    #1;
    total++;
    if ({ctrl_busy, master_read, user_valid} !== 3'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL abort_clear: got flags %b level %0d want 000/0",
               {ctrl_busy, master_read, user_valid}, fifo_level);
    end
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    tick(10);
    total++;
    if (fifo_level !== '0 || user_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_stale: got level %0d want 0", fifo_level);
    end
    user_read = 1'b1;
    start_xfer(32'h5000, 8);
    wait_done(200, ok);
    tick(15);
    total++;
    if (!ok || exp_q.size() != 0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL abort_restart: got ok=%0d left=%0d level=%0d want 1/0/0", ok, exp_q.size(),
               fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_len16();
    test_len13();
    test_wait();
    test_backpressure();
    test_len0();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
